sev_segm_scan: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode seven-segment digits. It holds `NUM_BYTES` display bytes and shares one external byte-to-seven-segment decoder between all of them. It steps through the 2·`NUM_BYTES` hex digits, one at a time, and drives the shared segment bus plus one active-low digit enable per digit. Host writes land in shadow registers and are committed only at a frame boundary, so a frame is never torn.

---
 rtl/sev_segm_scan_if.sv | 24 ++
 rtl/sev_segm_scan.sv | 175 +++++++++++++++++
 tb/tb_sev_segm_scan.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/sev_segm_scan_if.sv
// Host write channel of the seven-segment scan controller: valid/ready byte
// writes addressed by display byte index.
interface sev_segm_scan_if #(
    parameter int ADDR_W = 2
) ();
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sev_segm_scan.sv
// Time-multiplexed common-anode seven-segment scanner sharing one external
// byte decoder; host writes are double-buffered and committed per frame.
module sev_segm_scan #(
    parameter int NUM_BYTES   = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ADDR_W      = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    sev_segm_scan_if.slave         wr_bus,
    output logic [7:0]             dec_byte_o,
    input  logic [6:0]             dec_segm0_i,
    input  logic [6:0]             dec_segm1_i,
    output logic [6:0]             seg_out_o,
    output logic [2*NUM_BYTES-1:0] dig_en_o,
    output logic                   frame_done_o
);
    localparam int NUM_DIGITS = 2 * NUM_BYTES;
    localparam int DIG_W      = $clog2(NUM_DIGITS);
    localparam int CNT_W      = $clog2(REFRESH_DIV + 1);
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CAPTURE,
        ST_SHOW,
        ST_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [DIG_W-1:0]       digit_q, digit_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pending_q;
    logic [6:0]             seg_q;

    logic                   wr_ready_s;
    logic                   wr_accept;
    logic                   commit_en;
    logic [NUM_BYTES-1:0]   wr_hit;
    logic [8*NUM_BYTES-1:0] active_flat;
    logic [DIG_W-1:0]       byte_idx;
    logic [7:0]             byte_sel;

    assign wr_ready_s      = (state_q != ST_COMMIT);
    assign wr_bus.wr_ready = wr_ready_s;
    assign wr_accept       = wr_bus.wr_valid && wr_ready_s;

    // Disabling during COMMIT abandons the copy; the shadow stays pending.
    assign commit_en = (state_q == ST_COMMIT) && enable_i && pending_q;

    // Out-of-range addresses match no byte, so they are silently dropped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [7:0] shadow_q;
            logic [7:0] active_q;

            assign wr_hit[gi] = wr_accept && (wr_bus.wr_addr == ADDR_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    if (wr_hit[gi]) begin
                        shadow_q <= wr_bus.wr_data;
                    end
                    if (commit_en) begin
                        active_q <= shadow_q;
                    end
                end
            end

            assign active_flat[gi*8 +: 8] = active_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (|wr_hit) begin
            pending_q <= 1'b1;
        end else if (commit_en) begin
            pending_q <= 1'b0;
        end
    end

    assign byte_idx = digit_q >> 1;

    always_comb begin
        byte_sel = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_idx == DIG_W'(i)) begin
                byte_sel = active_flat[i*8 +: 8];
            end
        end
    end

    assign dec_byte_o = byte_sel;

    always_comb begin
        state_d = state_q;
        digit_d = digit_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                digit_d = '0;
                if (enable_i) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_SHOW;
            ST_SHOW: begin
                if (cnt_q == LAST_COUNT) begin
                    if (digit_q == LAST_DIGIT) begin
                        state_d = ST_COMMIT;
                    end else begin
                        digit_d = digit_q + DIG_W'(1);
                        state_d = ST_SELECT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                digit_d = '0;
                state_d = ST_SELECT;
            end
            default: begin
                digit_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (state_q != ST_IDLE && !enable_i) begin
            state_d = ST_IDLE;
            digit_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            digit_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
        end
    end

    // The decoder settles during SELECT; its output is sampled as CAPTURE ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 7'h7F;
        end else if (state_q == ST_CAPTURE) begin
            seg_q <= digit_q[0] ? dec_segm1_i : dec_segm0_i;
        end
    end

    assign seg_out_o    = seg_q;
    assign frame_done_o = (state_q == ST_COMMIT);

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign dig_en_o[gi] = !((state_q == ST_SHOW) && (digit_q == DIG_W'(gi)));
        end
    endgenerate
endmodule

// File: tb/tb_sev_segm_scan.sv
// Directed bench for sev_segm_scan with NUM_BYTES=2, REFRESH_DIV=4 and a
// behavioural hex-to-segment decoder on the shared decoder port.
module tb_sev_segm_scan;
    localparam int NB = 2;
    localparam int RD = 4;
    localparam int AW = 2;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] dec_byte;
    logic [6:0] segm0;
    logic [6:0] segm1;
    logic [6:0] seg_out;
    logic [3:0] dig_en;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    sev_segm_scan_if #(.ADDR_W(AW)) wr_if ();

    sev_segm_scan #(
        .NUM_BYTES  (NB),
        .REFRESH_DIV(RD),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .wr_bus      (wr_if),
        .dec_byte_o  (dec_byte),
        .dec_segm0_i (segm0),
        .dec_segm1_i (segm1),
        .seg_out_o   (seg_out),
        .dig_en_o    (dig_en),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_comb begin
        segm0 = hex2seg(dec_byte[3:0]);
        segm1 = hex2seg(dec_byte[7:4]);
    end

    task automatic chk(input string tag, input int ctx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s[%0d]: observed=%0h expected=%0h", tag, ctx, obs, exp);
        end
    endtask

    // Entered at the negedge just before the edge that moves the FSM into SELECT
    // of digit 0; walks one full frame and ends at the COMMIT negedge.
    task automatic run_frame(input logic [27:0] segs, input logic [15:0] bytes,
                             input int wr_digit, input logic [1:0] waddr, input logic [7:0] wdata,
                             input int abort_digit, input bit abort_rst);
        logic [3:0] mask;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            chk("sel_dig_en", d, 32'(dig_en), 32'hF);
            chk("sel_dec_byte", d, 32'(dec_byte), 32'(bytes[(d/2)*8 +: 8]));
            chk("sel_wr_ready", d, 32'(wr_if.wr_ready), 32'd1);
            @(negedge clk);
            if (d == 0) wr_if.wr_valid = 1'b0;
            chk("cap_dig_en", d, 32'(dig_en), 32'hF);
            chk("cap_frame_done", d, 32'(frame_done), 32'd0);
            if (abort_digit == d && !abort_rst) begin
                enable = 1'b0;
                return;
            end
            mask    = 4'hF;
            mask[d] = 1'b0;
            for (int k = 0; k < RD; k++) begin
                @(negedge clk);
                chk("show_dig_en", d * 10 + k, 32'(dig_en), 32'(mask));
                chk("show_seg", d * 10 + k, 32'(seg_out), 32'(segs[d*7 +: 7]));
                if (k == 0 && abort_rst && abort_digit == d) begin
                    rst_n = 1'b0;
                    return;
                end
                if (k == 0 && wr_digit == d) begin
                    wr_if.wr_valid = 1'b1;
                    wr_if.wr_addr  = waddr;
                    wr_if.wr_data  = wdata;
                end
                if (k == 1 && wr_digit == d) wr_if.wr_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("commit_frame_done", 0, 32'(frame_done), 32'd1);
        chk("commit_wr_ready", 0, 32'(wr_if.wr_ready), 32'd0);
        chk("commit_dig_en", 0, 32'(dig_en), 32'hF);
    endtask

    initial begin
        rst_n          = 1'b0;
        enable         = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;

        @(negedge clk);
        chk("rst_seg_out", 0, 32'(seg_out), 32'h7F);
        chk("rst_dig_en", 0, 32'(dig_en), 32'hF);
        chk("rst_dec_byte", 0, 32'(dec_byte), 32'h0);
        chk("rst_wr_ready", 0, 32'(wr_if.wr_ready), 32'd1);
        chk("rst_frame_done", 0, 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // Load byte0=3A, byte1=F0 while idle, ahead of the first COMMIT
        @(negedge clk);
        chk("idle_dig_en", 0, 32'(dig_en), 32'hF);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 8'h3A;
        chk("idle_wr_ready", 0, 32'(wr_if.wr_ready), 32'd1);
        @(negedge clk);
        wr_if.wr_addr = 2'd1;
        wr_if.wr_data = 8'hF0;
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        chk("idle_dig_en", 1, 32'(dig_en), 32'hF);
        enable = 1'b1;

        // Frame 1 still shows the reset contents
        run_frame({4{S0}}, 16'h0000, -1, 2'd0, 8'h00, -1, 1'b0);
        // Frame 2: A 3 0 F; byte1=55 written during digit 2 must not tear
        run_frame({SF, S0, S3, SA}, 16'hF03A, 2, 2'd1, 8'h55, -1, 1'b0);
        // Frame 3: A 3 5 5; out-of-range write to address 2
        run_frame({S5, S5, S3, SA}, 16'h553A, 0, 2'd2, 8'h00, -1, 1'b0);

        // Write presented during COMMIT stalls one cycle
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 2'd0;
        wr_if.wr_data  = 8'h12;
        chk("stall_wr_ready", 0, 32'(wr_if.wr_ready), 32'd0);
        run_frame({S5, S5, S3, SA}, 16'h553A, -1, 2'd0, 8'h00, -1, 1'b0);

        // Frame 5: 2 1 5 5, enable dropped in CAPTURE of digit 1
        run_frame({S5, S5, S1, S2}, 16'h5512, -1, 2'd0, 8'h00, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("off_dig_en", i, 32'(dig_en), 32'hF);
            chk("off_frame_done", i, 32'(frame_done), 32'd0);
        end
        enable = 1'b1;
        run_frame({S5, S5, S1, S2}, 16'h5512, -1, 2'd0, 8'h00, -1, 1'b0);

        // Asynchronous reset during SHOW of digit 3
        run_frame({S5, S5, S1, S2}, 16'h5512, -1, 2'd0, 8'h00, 3, 1'b1);
        #1;
        chk("midrst_dig_en", 0, 32'(dig_en), 32'hF);
        chk("midrst_seg_out", 0, 32'(seg_out), 32'h7F);
        chk("midrst_frame_done", 0, 32'(frame_done), 32'd0);
        chk("midrst_dec_byte", 0, 32'(dec_byte), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame({4{S0}}, 16'h0000, -1, 2'd0, 8'h00, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1);
    end
endmodule
